lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 RD_LAT, default 1, RAM read latency in cycles from address to valid ram_data_i; legal range 1..3.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 req_valid_i  input  1  core access request valid.
REQ-005 req_ready_o  output  1  LSU can accept a request.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 resp_valid_o  output  1  response valid.
REQ-011 resp_ready_i  input  1  core accepts response.
REQ-012 resp_rdata_o  output  32  formatted load data; 0 for stores and errors.
REQ-013 resp_err_o  output  1  access rejected: illegal funct3 or misaligned.
REQ-014 ram_addr_o  output  32  word-aligned RAM address {addr[31:2],2'b00}.
REQ-015 ram_data_o  output  32  lane-replicated store data to RAM.
REQ-016 ram_wen_o  output  4  RAM byte write enables; bit n writes byte lane n.
REQ-017 ram_data_i  input  32  RAM read data.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid_i=1 SHALL latch we/funct3/addr/wdata and go to ACCESS, or go directly to RESP with resp_err_o=1 and no RAM access when the request is illegal.
REQ-020 funct3 values 011, 110 and 111 SHALL be illegal; funct3 100 or 101 with req_we_i=1 SHALL be illegal.
REQ-021 Store lanes: SB wen=4'b0001<<addr[1:0], data={4{wdata[7:0]}}; SH wen=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}; SW wen=4'b1111, data=wdata.
REQ-022 A store SHALL assert ram_wen_o for exactly one cycle (the single ACCESS cycle), then go to RESP.
REQ-023 A load SHALL hold ram_wen_o=0 and stay in ACCESS for RD_LAT cycles, counted by a down-counter.
REQ-024 On the final ACCESS cycle of a load, the LSU SHALL sample ram_data_i, then go to RESP.
REQ-025 Load formatting: LB/LBU select byte addr[1:0], sign-/zero-extended; LH/LHU select halfword addr[1], sign-/zero-extended; LW passes the full word.
REQ-026 In RESP, resp_valid_o SHALL be 1 and resp_rdata_o/resp_err_o SHALL be stable until resp_ready_i=1, then return to IDLE.
REQ-027 ram_wen_o SHALL be 0 in every state except the store ACCESS cycle; ram_addr_o SHALL hold the latched word address through ACCESS.
REQ-028 Minimum latency from request acceptance to resp_valid_o SHALL be 2 cycles for a store and RD_LAT+1 cycles for a load; an error response SHALL take 1 cycle.
REQ-029 A back-to-back request SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-030 While rst_i=1, the FSM SHALL be forced to IDLE, the counter cleared, and req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, ram_wen_o, ram_addr_o and ram_data_o all driven to 0, asynchronously.
REQ-031 A reset asserted mid-ACCESS SHALL drop ram_wen_o immediately and discard the transaction without issuing a response.
REQ-032 req_ready_o SHALL become 1 in the first clock cycle after rst_i deasserts.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, H/HU with addr[0]=1 and W with addr[1:0]!=0 SHALL be rejected with resp_err_o=1 and no RAM access.
REQ-034 Without LSU_MISALIGN_TRAP_EN, misaligned H SHALL use addr[1] and ignore addr[0], misaligned W SHALL ignore addr[1:0], resp_err_o SHALL flag only illegal funct3, and RAM access SHALL proceed.

Verification
REQ-035 SB addr=0x6 wdata=0x000000AB -> ram_wen_o=0100, ram_data_o=0xABABABAB, ram_addr_o=0x4 for one cycle; resp_valid_o next cycle with err=0.
REQ-036 RAM word 0x8 holds 0x80F0_7F01; LB 0x9 -> 0x0000007F; LB 0xB -> 0xFFFFFF80; LHU 0xA -> 0x000080F0; LH 0xA -> 0xFFFF80F0.
REQ-037 RD_LAT=3, LW 0x10 -> resp_valid_o exactly 4 cycles after acceptance, rdata equals the RAM word.
REQ-038 LW addr=0x2 -> with LSU_MISALIGN_TRAP_EN: err=1, wen never asserted, resp after 1 cycle; without it: word at 0x0 returned, err=0.
REQ-039 Hold resp_ready_i=0 for 5 cycles -> resp_valid_o/rdata stable and req_ready_o=0 throughout; new request accepted only after the handshake.
REQ-040 SW 0x0 with rst_i pulsed during ACCESS -> ram_wen_o drops in the same cycle, no resp_valid_o, and req_ready_o=1 one cycle after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one outstanding RV32I access to a word-wide RAM with byte enables.
// Sequence is IDLE -> ACCESS -> RESP. Illegal requests skip ACCESS and go straight to RESP.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned halfword and
// word accesses are rejected. When it is undefined, the low address bits are ignored.
module lsu #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_wen_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_data_q;
  logic [3:0]  ram_wen_q;

  logic        reject_d;
  logic        misalign_d;

  // funct3 codes with no RV32I meaning, and unsigned variants used as stores.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b0;
      3'b100, 3'b101:         return we;
      default:                return 1'b1;
    endcase
  endfunction

  // Byte-enable pattern for a store of the given width at the given byte offset.
  function automatic logic [3:0] st_wen(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across the lanes so that the enables alone choose the bytes.
  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Extract the addressed byte or halfword from the RAM word, then sign- or zero-extend it.
  function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword accesses need addr[0]=0. Word accesses need addr[1:0]=0.
  assign misalign_d = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00));
`else
  // Misaligned accesses proceed. The lane logic drops the low address bits that do not apply.
  assign misalign_d = 1'b0;
`endif

  // Decide whether the request must be rejected without any RAM access.
  assign reject_d = f3_illegal(req_we_i, req_funct3_i) || misalign_d;

  // Control FSM. All outputs are registered. A reset drops every output at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      ram_addr_q   <= 32'd0;
      ram_data_q   <= 32'd0;
      ram_wen_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ready_q) begin
            // First cycle after reset: announce readiness before accepting anything.
            ready_q <= 1'b1;
          end else if (req_valid_i) begin
            ready_q <= 1'b0;
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[1:0];
            if (reject_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q    <= ACCESS;
              ram_addr_q <= {req_addr_i[31:2], 2'b00};
              ram_data_q <= req_we_i ? st_data(req_funct3_i, req_wdata_i) : 32'd0;
              ram_wen_q  <= req_we_i ? st_wen(req_funct3_i, req_addr_i[1:0]) : 4'd0;
              cnt_q      <= 2'(RD_LAT - 1);
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            // A store writes during exactly one cycle.
            ram_wen_q    <= 4'd0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
          end else if (cnt_q == 2'd0) begin
            // Read data becomes valid on the final ACCESS cycle of a load.
            resp_rdata_q <= ld_fmt(f3_q, off_q, ram_data_i);
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_data_o   = ram_data_q;
  assign ram_wen_o    = ram_wen_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu with a 3-cycle read-latency RAM model.
// The expected response is built from a byte-addressed reference memory.
module tb_lsu;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid_o;
  logic        resp_ready;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_wen_o;
  logic [31:0] ram_data_i;

  int n_vec = 0;
  int n_err = 0;

  // RAM word storage. The stimulus fills it only through the poke port.
  logic [31:0] mem [16];
  logic [31:0] pipe0, pipe1;
  logic        poke_en;
  logic [3:0]  poke_idx;
  logic [31:0] poke_val;

  // Reference memory, one entry per byte address.
  logic [7:0]  mb [64];

  always #5 clk = ~clk;

  lsu #(.RD_LAT(RD_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .ram_wen_o    (ram_wen_o),
    .ram_data_i   (ram_data_i)
  );

  // RAM model: byte-enabled writes, and reads that arrive RD_LAT cycles after the address.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    for (int k = 0; k < 4; k++)
      if (ram_wen_o[k]) mem[ram_addr_o[5:2]][8*k +: 8] <= ram_data_o[8*k +: 8];
    pipe0 <= mem[ram_addr_o[5:2]];
    pipe1 <= pipe0;
  end
  assign ram_data_i = pipe1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = 4'(idx);
    poke_val = val;
    for (int j = 0; j < 4; j++) mb[4*idx + j] = val[8*j +: 8];
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // One complete request/response transaction, checked against the reference memory.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int stall);
    int          sz, ea, lat, exp_lat, wen_cyc, guard;
    bit          legal, mis, err;
    logic [31:0] exp_rd, exp_wen, exp_dat, held;
    logic [3:0]  seen_wen;
    logic [31:0] seen_dat;

    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
    sz = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (addr % sz) != 0;
`else
    mis = 1'b0;
`endif
    err     = !legal || mis;
    ea      = int'(addr) - int'(addr % sz);
    exp_lat = err ? 1 : (we ? 2 : RD_LAT + 1);
    exp_rd  = 32'd0;
    exp_wen = 32'd0;
    exp_dat = 32'd0;
    if (!err && !we) begin
      for (int j = 0; j < sz; j++) exp_rd = exp_rd | (32'(mb[ea + j]) << (8 * j));
      if (!f3[2] && sz < 4 && exp_rd[8*sz-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * sz));
    end
    if (!err && we) begin
      exp_wen = ((32'd1 << sz) - 32'd1) << (ea % 4);
      for (int i = 0; i < 4; i++) exp_dat[8*i +: 8] = wdata[8*(i % sz) +: 8];
    end

    guard = 0;
    @(negedge clk);
    while (!req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(req_ready_o), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    lat = 1;
    wen_cyc = 0;
    seen_wen = 4'd0;
    seen_dat = 32'd0;
    while (!resp_valid_o && lat < 10) begin
      chk("ram_addr_access", ram_addr_o, 32'(ea) & 32'hFFFF_FFFC);
      if (ram_wen_o != 4'd0) begin
        wen_cyc++;
        seen_wen = ram_wen_o;
        seen_dat = ram_data_o;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_valid", 32'(resp_valid_o), 32'd1);
    chk("resp_err", 32'(resp_err_o), 32'(err));
    chk("resp_rdata", resp_rdata_o, exp_rd);
    chk("wen_cycles", 32'(wen_cyc), (!err && we) ? 32'd1 : 32'd0);
    chk("wen_in_resp", 32'(ram_wen_o), 32'd0);
    if (!err && we) begin
      chk("store_wen", 32'(seen_wen), exp_wen);
      chk("store_data", seen_dat, exp_dat);
      for (int j = 0; j < sz; j++) mb[ea + j] = wdata[8*j +: 8];
    end

    held = resp_rdata_o;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid_o), 32'd1);
      chk("stall_rdata", resp_rdata_o, held);
      chk("stall_err", 32'(resp_err_o), 32'(err));
      chk("stall_ready", 32'(req_ready_o), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("after_hs_valid", 32'(resp_valid_o), 32'd0);
    chk("after_hs_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    poke_en    = 1'b0;
    poke_idx   = 4'd0;
    poke_val   = 32'd0;

    // Fill RAM and the reference memory while the LSU is held in reset.
    #1;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_ram_wen", 32'(ram_wen_o), 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    chk("rst_ram_data", ram_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready_o), 32'd1);

    // SB to byte 2 of word 4.
    xact(1'b1, 3'b000, 32'h6, 32'h0000_00AB, 0);

    // Byte and halfword loads from a known word, including sign extension.
    poke(2, 32'h80F0_7F01);
    xact(1'b0, 3'b000, 32'h9, 32'h0, 0);
    xact(1'b0, 3'b000, 32'hB, 32'h0, 0);
    xact(1'b0, 3'b101, 32'hA, 32'h0, 0);
    xact(1'b0, 3'b001, 32'hA, 32'h0, 0);
    xact(1'b0, 3'b100, 32'hB, 32'h0, 0);

    // Word load. The latency check covers RD_LAT+1.
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0);

    // Misaligned word and halfword accesses. The expected result depends on the build macro.
    xact(1'b0, 3'b010, 32'h2, 32'h0, 0);
    xact(1'b1, 3'b001, 32'h21, 32'hCAFE_1234, 0);
    xact(1'b0, 3'b001, 32'h21, 32'h0, 0);

    // Hold the response for five cycles.
    xact(1'b0, 3'b010, 32'h8, 32'h0, 5);

    // Illegal funct3 values, and unsigned widths used as stores.
    xact(1'b0, 3'b011, 32'h0, 32'h0, 0);
    xact(1'b0, 3'b110, 32'h4, 32'h0, 1);
    xact(1'b1, 3'b111, 32'h8, 32'h1, 0);
    xact(1'b1, 3'b100, 32'hC, 32'h2, 0);
    xact(1'b1, 3'b101, 32'h10, 32'h3, 0);

    // Reset pulse during the ACCESS cycle of a store.
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h1357_9BDF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rst_wen_before", 32'(ram_wen_o), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wen_drop", 32'(ram_wen_o), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
    chk("mid_rst_ready_low", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid_rel", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_rel", 32'(req_ready_o), 32'd1);
    chk("mid_rst_no_resp", 32'(resp_valid_o), 32'd0);
    // The aborted store must not have changed word 0.
    xact(1'b0, 3'b010, 32'h0, 32'h0, 0);

    // Random traffic checked against the reference memory.
    for (int t = 0; t < 150; t++) begin
      xact(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom,
           int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
